// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Stall masks are indexed by stage: bit0 PC ... bit5 WB, 1 = hold.
package hazard_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    typedef logic [STALL_BUS_W-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // PC, IF/ID and ID/EX hold while EX/MEM runs on, which injects a bubble into EX.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_LU   = 6'b000111;
    localparam stall_bus_t STALL_DIV  = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic {
        HC_IDLE = 1'b0,
        HC_DIV  = 1'b1
    } hc_state_e;

    // Load-use match of one ID operand against the EX destination register.
    function automatic logic operand_hit(input logic       uses,
                                         input logic [4:0] src,
                                         input logic [4:0] waddr);
        return uses && (src == waddr);
    endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Stall controller: merges load-use hazards, a fixed-latency divide sequencer
// and data-SRAM wait into one per-stage hold mask, plus a stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_stallreq,
    input  logic        ex_is_load,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_waddr,
    input  logic        div_start,
    input  logic        mem_wait,
    output logic [5:0]  stall,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] stall_cycles
);

    localparam logic [5:0] CNT_INIT = 6'(DIV_LAT - 1);

    hc_state_e  state;
    logic [5:0] cnt;
    logic       cnt_zero;
    logic       lu;

    assign cnt_zero = (cnt == 6'd0);

    assign lu = id_stallreq
              | (ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0)
                 && (operand_hit(id_uses_rs, id_rs, ex_rf_waddr)
                     || operand_hit(id_uses_rt, id_rt, ex_rf_waddr)));

    // A finished divide waits for the memory stage, so done needs mem_wait low.
    assign div_done = (state == HC_DIV) && cnt_zero && !mem_wait;
    assign div_busy = (state == HC_DIV);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stall = STALL_NONE;
        if (mem_wait)
            stall = STALL_MEM;
        else if (((state == HC_IDLE) && div_start) || ((state == HC_DIV) && !cnt_zero))
            stall = STALL_DIV;
        else if ((state == HC_IDLE) && lu)
            stall = STALL_LU;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HC_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                HC_IDLE: begin
                    if (div_start) begin
                        cnt   <= CNT_INIT;
                        state <= HC_DIV;
                    end
                end
                HC_DIV: begin
                    // The counter keeps running under mem_wait; only completion is deferred.
                    if (!cnt_zero)
                        cnt <= cnt - 6'd1;
                    else if (!mem_wait)
                        state <= HC_IDLE;
                end
                default: begin
                    state <= HC_IDLE;
                    cnt   <= 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= 32'd0;
        else if (stall[0] == STOP)
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a short divide latency.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rf_waddr;
    logic        id_uses_rs, id_uses_rt, id_stallreq;
    logic        ex_is_load, ex_rf_we, div_start, mem_wait;
    logic [5:0]  stall;
    logic        div_busy, div_done;
    logic [31:0] stall_cycles;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_stallreq(id_stallreq),
        .ex_is_load(ex_is_load), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
        .div_start(div_start), .mem_wait(mem_wait),
        .stall(stall), .div_busy(div_busy), .div_done(div_done),
        .stall_cycles(stall_cycles)
    );

    // A divide and a load can never share EX in a legal instruction stream.
    always @(posedge clk) begin
        if (!rst && div_start && ex_is_load) begin
            n_total++;
            $display("FAIL div_and_load_in_ex: div_start=1 and ex_is_load=1 together (required never)");
            assert (0) else $error("div_start and ex_is_load asserted together");
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_stallreq = 1'b0; ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = 5'd0;
        div_start = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        do_reset();
        #1;
        n_total++; if (stall !== STALL_NONE) $display("FAIL reset_stall: got %b want %b", stall, STALL_NONE); else n_pass++;
        n_total++; if (div_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", div_busy); else n_pass++;
        n_total++; if (div_done !== 1'b0) $display("FAIL reset_done: got %b want 0", div_done); else n_pass++;
        n_total++; if (stall_cycles !== 32'd0) $display("FAIL reset_cycles: got %0d want 0", stall_cycles); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        // EX: lw $3 ; ID: addu $5,$3,$4
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3;
        id_rs = 5'd3; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        #1;
        n_total++; if (stall !== STALL_LU) $display("FAIL lu_rs: got %b want %b", stall, STALL_LU); else n_pass++;
        @(negedge clk);
        idle_inputs();
        id_rs = 5'd3; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        #1;
        n_total++; if (stall !== STALL_NONE) $display("FAIL lu_release: got %b want %b", stall, STALL_NONE); else n_pass++;
        n_total++; if (stall_cycles !== 32'd1) $display("FAIL lu_cycles: got %0d want 1", stall_cycles); else n_pass++;
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd7;
        id_rs = 5'd2; id_rt = 5'd7; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        #1;
        n_total++; if (stall !== STALL_LU) $display("FAIL lu_rt: got %b want %b", stall, STALL_LU); else n_pass++;
        @(negedge clk);
        idle_inputs();
        id_stallreq = 1'b1;
        #1;
        n_total++; if (stall !== STALL_LU) $display("FAIL lu_stallreq: got %b want %b", stall, STALL_LU); else n_pass++;
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++; if (stall_cycles !== 32'd3) $display("FAIL lu_cycles_total: got %0d want 3", stall_cycles); else n_pass++;
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        // lw $0 with ID reading $0
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        n_total++; if (stall !== STALL_NONE) $display("FAIL nofalse_r0: got %b want %b", stall, STALL_NONE); else n_pass++;
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b0; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        n_total++; if (stall !== STALL_NONE) $display("FAIL nofalse_notload: got %b want %b", stall, STALL_NONE); else n_pass++;
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd3;
        id_rs = 5'd9; id_uses_rs = 1'b1; id_rt = 5'd3; id_uses_rt = 1'b0;
        #1;
        n_total++; if (stall !== STALL_NONE) $display("FAIL nofalse_rt_unused: got %b want %b", stall, STALL_NONE); else n_pass++;
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_rf_we = 1'b0; ex_rf_waddr = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        n_total++; if (stall !== STALL_NONE) $display("FAIL nofalse_no_we: got %b want %b", stall, STALL_NONE); else n_pass++;
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++; if (stall_cycles !== 32'd0) $display("FAIL nofalse_cycles: got %0d want 0", stall_cycles); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        mem_wait = 1'b1; id_stallreq = 1'b1;
        #1;
        n_total++; if (stall !== STALL_MEM) $display("FAIL prio_mem_over_lu: got %b want %b", stall, STALL_MEM); else n_pass++;
        @(negedge clk);
        idle_inputs();
        div_start = 1'b1;
        @(negedge clk);
        // In DIV with cnt != 0 a pending load-use request is masked by the divide stall.
        div_start = 1'b0; id_stallreq = 1'b1;
        #1;
        n_total++; if (stall !== STALL_DIV) $display("FAIL prio_div_over_lu: got %b want %b", stall, STALL_DIV); else n_pass++;
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 2 * LAT && div_busy; i++) @(negedge clk);
        #1;
        n_total++; if (div_busy !== 1'b0) $display("FAIL prio_div_drain: got busy=%b want 0", div_busy); else n_pass++;
    endtask

    task automatic test_divide();
        do_reset();
        div_start = 1'b1;
        #1;
        n_total++; if (stall !== STALL_DIV || div_busy !== 1'b0 || div_done !== 1'b0)
            $display("FAIL div_start_cycle: got stall=%b busy=%b done=%b want %b 0 0", stall, div_busy, div_done, STALL_DIV);
        else n_pass++;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk); #1;
            n_total++; if (stall !== STALL_DIV || div_busy !== 1'b1 || div_done !== 1'b0)
                $display("FAIL div_run_%0d: got stall=%b busy=%b done=%b want %b 1 0", k, stall, div_busy, div_done, STALL_DIV);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_total++; if (stall !== STALL_NONE || div_busy !== 1'b1 || div_done !== 1'b1)
            $display("FAIL div_done_cycle: got stall=%b busy=%b done=%b want %b 1 1", stall, div_busy, div_done, STALL_NONE);
        else n_pass++;
        n_total++; if (stall_cycles !== 32'd4) $display("FAIL div_cycles: got %0d want 4", stall_cycles); else n_pass++;
        @(negedge clk);
        div_start = 1'b0;
        #1;
        n_total++; if (stall !== STALL_NONE || div_busy !== 1'b0 || div_done !== 1'b0)
            $display("FAIL div_after: got stall=%b busy=%b done=%b want %b 0 0", stall, div_busy, div_done, STALL_NONE);
        else n_pass++;
    endtask

    task automatic test_mem_overlap();
        int dones;
        dones = 0;
        do_reset();
        div_start = 1'b1;
        #1;
        if (div_done) dones++;
        n_total++; if (stall !== STALL_DIV) $display("FAIL ovl_start: got %b want %b", stall, STALL_DIV); else n_pass++;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            mem_wait = 1'b1;
            #1;
            if (div_done) dones++;
            n_total++; if (stall !== STALL_MEM || div_done !== 1'b0)
                $display("FAIL ovl_wait_%0d: got stall=%b done=%b want %b 0", k, stall, div_done, STALL_MEM);
            else n_pass++;
        end
        @(negedge clk);
        mem_wait = 1'b0;
        #1;
        if (div_done) dones++;
        n_total++; if (stall !== STALL_NONE || div_done !== 1'b1)
            $display("FAIL ovl_done: got stall=%b done=%b want %b 1", stall, div_done, STALL_NONE);
        else n_pass++;
        @(negedge clk);
        div_start = 1'b0;
        #1;
        if (div_done) dones++;
        n_total++; if (div_busy !== 1'b0) $display("FAIL ovl_busy_fall: got %b want 0", div_busy); else n_pass++;
        n_total++; if (dones !== 1) $display("FAIL ovl_done_count: got %0d want 1", dones); else n_pass++;
        n_total++; if (stall_cycles !== 32'd7) $display("FAIL ovl_cycles: got %0d want 7", stall_cycles); else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        int dones;
        dones = 0;
        do_reset();
        div_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_total++; if (stall !== STALL_DIV) $display("FAIL rstdiv_before: got %b want %b", stall, STALL_DIV); else n_pass++;
        @(negedge clk);
        rst = 1'b0; div_start = 1'b0;
        #1;
        n_total++; if (stall !== STALL_NONE || div_busy !== 1'b0 || stall_cycles !== 32'd0)
            $display("FAIL rstdiv_after: got stall=%b busy=%b cycles=%0d want %b 0 0", stall, div_busy, stall_cycles, STALL_NONE);
        else n_pass++;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(negedge clk); #1;
            if (div_done || div_busy) dones++;
        end
        n_total++; if (dones !== 0) $display("FAIL rstdiv_no_done: got %0d done/busy cycles want 0", dones); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        n_total++; if (stall_cycles !== 32'hFFFF_FFFE) $display("FAIL wrap_preload: got %h want fffffffe", stall_cycles); else n_pass++;
        mem_wait = 1'b1;
        @(negedge clk); #1;
        n_total++; if (stall_cycles !== 32'hFFFF_FFFF) $display("FAIL wrap_max: got %h want ffffffff", stall_cycles); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (stall_cycles !== 32'h0) $display("FAIL wrap_zero: got %h want 00000000", stall_cycles); else n_pass++;
        @(negedge clk);
        mem_wait = 1'b0;
        #1;
        n_total++; if (stall_cycles !== 32'h1) $display("FAIL wrap_one: got %h want 00000001", stall_cycles); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (stall_cycles !== 32'h1) $display("FAIL wrap_hold: got %h want 00000001", stall_cycles); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_priority();
        test_divide();
        test_mem_overlap();
        test_reset_mid_div();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline stall controller for the five-stage MIPS core. It owns the `stall` bus consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It merges three sources: load-use hazards detected against the instruction in ID, a fixed-latency multi-cycle divide sequenced by an internal counter, and data-SRAM wait. It also keeps a free-running stall-cycle performance counter.

## Interface
Parameters:
- `DIV_LAT`, default 32: divide latency in cycles, valid range 2..63.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `id_rs`, `id_rt`, in, 5 each: source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`, in, 1 each: the ID instruction actually reads that operand.
- `id_stallreq`, in, 1: generic stall request from ID; same effect as a load-use hazard.
- `ex_is_load`, in, 1: the instruction in EX is a load.
- `ex_rf_we`, in, 1: the instruction in EX writes the register file.
- `ex_rf_waddr`, in, 5: destination register of the instruction in EX.
- `div_start`, in, 1: a div/divu is in EX and requests the divider.
- `mem_wait`, in, 1: data SRAM not ready; the access in MEM must hold.
- `stall`, out, `StallBus` (6): per-stage hold mask. Bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB. `Stop`=1.
- `div_busy`, out, 1: divider occupied.
- `div_done`, out, 1: one-cycle pulse; the divide result is valid in EX this cycle.
- `stall_cycles`, out, 32: count of cycles with `stall[0]==Stop`.

## Operation
- Stall patterns:
  - `STALL_NONE` = 6'b000000.
  - `STALL_LU` = 6'b000111. A bubble enters EX because `stall[2]`=Stop and `stall[3]`=NoStop.
  - `STALL_DIV` = 6'b001111.
  - `STALL_MEM` = 6'b011111.
- Load-use hazard `lu` is true when all of the following hold:
  - `ex_is_load & ex_rf_we & (ex_rf_waddr != 0)`;
  - and either `(id_uses_rs & id_rs==ex_rf_waddr)` or `(id_uses_rt & id_rt==ex_rf_waddr)`.
  - `id_stallreq` is ORed into `lu`.
- FSM, two states:
  - **IDLE**:
    - `div_start` → load `cnt` with `DIV_LAT-1`, go to DIV. `div_busy` rises the next cycle.
    - Otherwise stay in IDLE.
  - **DIV**:
    - If `cnt != 0`: decrement `cnt` every cycle, including cycles with `mem_wait` high.
    - If `cnt == 0` and `mem_wait`=0: pulse `div_done`, go to IDLE.
    - If `cnt == 0` and `mem_wait`=1: hold in DIV with `cnt`=0, keep `div_done` low.
- `stall` is combinational, first match wins:
  1. `mem_wait` → `STALL_MEM`.
  2. `(IDLE & div_start) | (DIV & cnt != 0)` → `STALL_DIV`.
  3. `IDLE & lu` → `STALL_LU`.
  4. Otherwise `STALL_NONE`.
- DIV with `cnt == 0` releases the stall in the same cycle as `div_done`.
- `div_start` is ignored in DIV. EX is frozen there, so the request is the same instruction.
- If `div_start` and `ex_is_load` are high together, the divide wins. Flag this as an assertion failure in the bench.
- `stall_cycles` increments by 1 whenever `stall[0]==Stop`. It wraps from 0xFFFFFFFF to 0.
- `cnt` is a 6-bit register.

## Timing
- Reset values: state=IDLE, `cnt`=0, `stall`=0, `div_busy`=0, `div_done`=0, `stall_cycles`=0.
- Reset mid-divide aborts the divide immediately: outputs return to the reset values the cycle after `rst`, and no `div_done` is issued.
- Load-use:
  - `stall` is asserted in the same cycle the hazard is visible, with zero latency.
  - The hazard clears once the load advances to MEM, so the stall lasts exactly 1 cycle when `mem_wait`=0.
- Divide with `mem_wait` low:
  - `stall`=`STALL_DIV` for exactly `DIV_LAT` cycles: the start cycle plus `DIV_LAT-1` cycles in DIV.
  - `div_done` is high `DIV_LAT` cycles after the start cycle.
- `div_busy` = (state == DIV). It falls the cycle after `div_done`.
- `mem_wait` overlapping a divide:
  - Stall cycles = max(`DIV_LAT`, cycles until `mem_wait` drops).
  - `div_done` is deferred to the first cycle with `cnt==0` and `mem_wait`=0.

## Structure
- `lib/defines.vh` holds:
  - `StallBus` (6), `Stop` (1'b1), `NoStop` (1'b0);
  - the four stall-pattern macros;
  - the state encodings `HC_IDLE`/`HC_DIV`.
- Single module, no sub-modules. The counter and FSM are too small to split.

## Test plan
- Load-use: EX `lw $3`, ID `addu $5,$3,$4` with `id_uses_rs`=1 → `stall`=000111 for 1 cycle, then 000000; `stall_cycles`=1.
- No false hazard:
  - `lw` to `$0` → no stall.
  - `ex_is_load`=0 with matching register → no stall.
  - `id_uses_rt`=0 with `id_rt` matching → no stall.
- Divide with `DIV_LAT`=4: `div_start` at cycle t → `stall`=001111 at t..t+3, `div_done` at t+4 with `stall`=0, `div_busy` high t+1..t+4, `stall_cycles`=4.
- `mem_wait` held for 6 cycles from t+1 during a `DIV_LAT`=4 divide → `stall`=011111 at t+1..t+6, `div_done` at t+7 exactly once.
- `rst` asserted at t+2 of a divide → at t+3 `stall`=0, `div_busy`=0, `stall_cycles`=0; no `div_done` follows.
- Counter wrap: preload `stall_cycles` near max (force), 3 stall cycles → reads 1 after 0xFFFFFFFF → 0 → 1.
